// File: rtl/ps2_key_tracker_pkg.sv
// Shared PS/2 definitions: key_state bit positions, set-2 scan codes and the
// receiver state encoding used by the front end and the move decoder.
package ps2_key_tracker_pkg;

  localparam int KS_LEFT  = 0;
  localparam int KS_UP    = 1;
  localparam int KS_RIGHT = 2;
  localparam int KS_DOWN  = 3;
  localparam int KS_JUMP  = 4;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_BATF  = 8'hFC;
  localparam logic [7:0] SC_ERR0  = 8'h00;
  localparam logic [7:0] SC_ERRF  = 8'hFF;

  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } rx_state_e;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: pin synchronizers, falling-edge detect,
// start/data/parity/stop FSM and an inactivity timeout.
module ps2_rx
  import ps2_key_tracker_pkg::*;
#(
  parameter int FRAME_TIMEOUT = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [1:0] state_dbg
);

  localparam int TW = $clog2(FRAME_TIMEOUT + 1);

  logic       clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic       dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d;
  rx_state_e  state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0] byte_q, byte_d;
  logic       valid_q, valid_d, err_q, err_d;
  logic       fall;

  // rx_valid and rx_err are single-cycle strobes with no ready: the consumer
  // must take rx_byte in the cycle rx_valid is high or the byte is lost.
  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    dat_s1_d   = ps2_data;
    dat_s2_d   = dat_s1_q;
    fall       = clk_prev_q & ~clk_s2_q;
    state_d    = state_q;
    shift_d    = shift_q;
    bcnt_d     = bcnt_q;
    byte_d     = byte_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    tcnt_d     = (state_q == RX_IDLE || fall) ? '0 : tcnt_q + TW'(1);
    if (fall) begin
      case (state_q)
        RX_IDLE: begin
          // A high data line on a clock edge is treated as line noise.
          if (!dat_s2_q) begin
            state_d = RX_DATA;
            bcnt_d  = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d = {dat_s2_q, shift_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          if (^{shift_q, dat_s2_q}) begin
            state_d = RX_STOP;
          end else begin
            state_d = RX_IDLE;
            err_d   = 1'b1;
          end
        end
        RX_STOP: begin
          state_d = RX_IDLE;
          if (dat_s2_q) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end else if (state_q != RX_IDLE && tcnt_q == TW'(FRAME_TIMEOUT - 1)) begin
      // Edge handling takes priority, so a frame finishing on the expiry cycle wins.
      state_d = RX_IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      state_q    <= RX_IDLE;
      shift_q    <= '0;
      bcnt_q     <= '0;
      tcnt_q     <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_prev_q <= clk_prev_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcnt_q     <= bcnt_d;
      tcnt_q     <= tcnt_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign rx_byte   = byte_q;
  assign rx_valid  = valid_q;
  assign rx_err    = err_q;
  assign state_dbg = state_q;

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard front end: receives scan-code bytes and tracks which game keys
// are held, merging the letter and arrow clusters into key_state.
module ps2_key_tracker
  import ps2_key_tracker_pkg::*;
#(
  parameter int FRAME_TIMEOUT = 200000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] key_state,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err,
  output logic [1:0] rx_state
);

  logic       brk_q, brk_d, ext_q, ext_d;
  logic [4:0] letter_q, letter_d;
  logic [3:0] arrow_q, arrow_d;

  ps2_rx #(.FRAME_TIMEOUT(FRAME_TIMEOUT)) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .state_dbg (rx_state)
  );

  always_comb begin
    brk_d    = brk_q;
    ext_d    = ext_q;
    letter_d = letter_q;
    arrow_d  = arrow_q;
    if (rx_valid) begin
      case (rx_byte)
        SC_BREAK: brk_d = 1'b1;
        SC_EXT:   ext_d = 1'b1;
        SC_BAT, SC_BATF, SC_ERR0, SC_ERRF: begin
          brk_d    = 1'b0;
          ext_d    = 1'b0;
          letter_d = '0;
          arrow_d  = '0;
        end
        default: begin
          // Prefixes apply to exactly one following code, mapped or not.
          brk_d = 1'b0;
          ext_d = 1'b0;
          if (ext_q) begin
            case (rx_byte)
              SC_LEFT:  arrow_d[KS_LEFT]  = ~brk_q;
              SC_UP:    arrow_d[KS_UP]    = ~brk_q;
              SC_RIGHT: arrow_d[KS_RIGHT] = ~brk_q;
              SC_DOWN:  arrow_d[KS_DOWN]  = ~brk_q;
              default:  ;
            endcase
          end else begin
            case (rx_byte)
              SC_A:     letter_d[KS_LEFT]  = ~brk_q;
              SC_W:     letter_d[KS_UP]    = ~brk_q;
              SC_D:     letter_d[KS_RIGHT] = ~brk_q;
              SC_S:     letter_d[KS_DOWN]  = ~brk_q;
              SC_SPACE: letter_d[KS_JUMP]  = ~brk_q;
              default:  ;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      brk_q    <= 1'b0;
      ext_q    <= 1'b0;
      letter_q <= '0;
      arrow_q  <= '0;
    end else begin
      brk_q    <= brk_d;
      ext_q    <= ext_d;
      letter_q <= letter_d;
      arrow_q  <= arrow_d;
    end
  end

  assign key_state = letter_q | {1'b0, arrow_q};

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: directed PS/2 frames, receiver strobes checked
// against an expected queue by a monitor, key_state checked after each frame.
module tb_ps2_key_tracker;

  localparam int TMO  = 300;
  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [4:0] key_state;
  logic [7:0] rx_byte;
  logic       rx_valid, rx_err;
  logic [1:0] rx_state;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stop_cyc = 0;
  // {timeout, err, byte}
  logic [9:0] exp_q[$];

  ps2_key_tracker #(.FRAME_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_state (key_state),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .rx_err    (rx_err),
    .rx_state  (rx_state)
  );

  // clock/reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks (inputs change on negedge)
  task automatic ps2_bit(input logic b, input logic is_stop);
    ps2_data = b;
    repeat (4) @(negedge clk);
    ps2_clk = 1'b0;
    if (is_stop) stop_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    exp_q.push_back({1'b0, bad_par, b});
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit(par, bad_par);
    if (!bad_par) ps2_bit(1'b1, 1'b1);
    ps2_data = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0);
    ps2_data = 1'b1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && (rx_valid || rx_err)) begin
      logic [9:0] e;
      if (rx_valid && rx_err) begin
        total++; bad++;
        $display("FAIL both_strobes: valid=%0b err=%0b expected one only", rx_valid, rx_err);
      end
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe: valid=%0b err=%0b byte=%0h expected none", rx_valid, rx_err, rx_byte);
      end else begin
        e = exp_q.pop_front();
        if (rx_err !== e[8] || (!e[8] && rx_byte !== e[7:0])) begin
          bad++;
          $display("FAIL strobe: err=%0b byte=%0h expected err=%0b byte=%0h", rx_err, rx_byte, e[8], e[7:0]);
        end
        if (!e[9]) begin
          total++;
          if (cyc - stop_cyc != 3) begin
            bad++;
            $display("FAIL strobe_latency: got %0d expected 3", cyc - stop_cyc);
          end
        end
      end
    end
  end

  initial begin
    repeat (4) @(negedge clk);
    check("reset_key_state", 16'(key_state), 16'h0);
    check("reset_rx_byte", 16'(rx_byte), 16'h0);
    check("reset_strobes", 16'({rx_valid, rx_err}), 16'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_fsm_idle", 16'(rx_state), 16'h0);

    send_frame(8'h1D, 1'b0);
    check("w_make", 16'(key_state), 16'h02);
    check("w_rx_byte", 16'(rx_byte), 16'h1D);
    send_frame(8'hF0, 1'b0); send_frame(8'h1D, 1'b0);
    check("w_break", 16'(key_state), 16'h00);

    send_frame(8'hE0, 1'b0); send_frame(8'h6B, 1'b0);
    check("arrow_left_make", 16'(key_state), 16'h01);
    send_frame(8'h1C, 1'b0);
    check("a_make_overlap", 16'(key_state), 16'h01);
    send_frame(8'hE0, 1'b0); send_frame(8'hF0, 1'b0); send_frame(8'h6B, 1'b0);
    check("arrow_left_break_a_held", 16'(key_state), 16'h01);
    send_frame(8'hF0, 1'b0); send_frame(8'h1C, 1'b0);
    check("a_break", 16'(key_state), 16'h00);

    send_frame(8'h29, 1'b1);
    check("bad_parity_keys", 16'(key_state), 16'h00);
    check("bad_parity_rx_byte", 16'(rx_byte), 16'h1C);
    send_frame(8'h29, 1'b0);
    check("space_make", 16'(key_state), 16'h10);
    send_frame(8'hF0, 1'b0); send_frame(8'h29, 1'b0);
    check("space_break", 16'(key_state), 16'h00);

    exp_q.push_back({1'b1, 1'b1, 8'h00});
    send_partial(8'h23, 5);
    repeat (TMO + 40) @(negedge clk);
    check("timeout_fsm_idle", 16'(rx_state), 16'h0);
    send_frame(8'h23, 1'b0);
    check("d_after_timeout", 16'(key_state), 16'h04);
    send_frame(8'hF0, 1'b0); send_frame(8'h23, 1'b0);
    check("d_break", 16'(key_state), 16'h00);

    send_frame(8'h1D, 1'b0); send_frame(8'h23, 1'b0); send_frame(8'h29, 1'b0);
    check("hold_w_d_space", 16'(key_state), 16'h16);
    send_frame(8'hAA, 1'b0);
    check("bat_clears", 16'(key_state), 16'h00);
    check("bat_rx_byte", 16'(rx_byte), 16'hAA);

    for (int i = 0; i < 3; i++) begin
      send_frame(8'h1B, 1'b0);
      check("s_repeat", 16'(key_state), 16'h08);
    end
    send_frame(8'hF0, 1'b0); send_frame(8'h1B, 1'b0);
    check("s_break", 16'(key_state), 16'h00);
    send_frame(8'hE0, 1'b0); send_frame(8'h12, 1'b0);
    check("unmapped_ext", 16'(key_state), 16'h00);
    check("unmapped_rx_byte", 16'(rx_byte), 16'h12);
    // the ext prefix must have been consumed by the unmapped code
    send_frame(8'h6B, 1'b0);
    check("ext_cleared_after_unmapped", 16'(key_state), 16'h00);

    send_frame(8'h1C, 1'b0);
    check("a_before_reset", 16'(key_state), 16'h01);
    send_partial(8'h75, 4);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_keys", 16'(key_state), 16'h00);
    check("midreset_rx_byte", 16'(rx_byte), 16'h00);
    check("midreset_strobes", 16'({rx_valid, rx_err}), 16'h0);
    rst_n = 1'b1;
    repeat (TMO + 40) @(negedge clk);
    check("midreset_fsm_idle", 16'(rx_state), 16'h0);
    send_frame(8'h1D, 1'b0);
    check("w_after_reset", 16'(key_state), 16'h02);

    repeat (10) @(negedge clk);
    check("queue_drained", 16'(exp_q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
